// File: rtl/soc_system_pll_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// The slave side is the sequencer; the master side drives lock status and relock requests.
interface soc_system_pll_reset_seq_if;
    logic       pll_locked;
    logic       sw_relock;
    logic       pll_rst;
    logic       rst_out0;
    logic       rst_out1;
    logic       ready;
    logic [7:0] lock_lost_cnt;
    logic       timeout_err;

    modport master (
        output pll_locked, sw_relock,
        input  pll_rst, rst_out0, rst_out1, ready, lock_lost_cnt, timeout_err
    );

    modport slave (
        input  pll_locked, sw_relock,
        output pll_rst, rst_out0, rst_out1, ready, lock_lost_cnt, timeout_err
    );
endinterface

// File: rtl/soc_system_pll_reset_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the outclk_0 and outclk_1 domain resets in order; retries on timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RESET | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting for locked_s, retry after LOCK_TIMEOUT_CYCLES
// STABLE    | locked_s must stay high LOCK_STABLE_CYCLES in a row
// RELEASE   | rst_out0 released, rst_out1 held for RELEASE_GAP
// RUN       | both resets released, ready high
module soc_system_pll_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 10,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned RELEASE_GAP         = 16
) (
    input  logic                        refclk,
    input  logic                        rst,
    soc_system_pll_reset_seq_if.slave   bus
);

    localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CD  = (LOCK_TIMEOUT_CYCLES > RELEASE_GAP) ? LOCK_TIMEOUT_CYCLES : RELEASE_GAP;
    localparam int unsigned MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [2:0] PLL_RESET = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RELEASE   = 3'd3;
    localparam logic [2:0] RUN       = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync1, locked_s;
    logic             lock_loss, set_timeout;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= bus.pll_locked;
            locked_s <= sync1;
        end
    end

    assign lock_loss = !locked_s && ((state == RELEASE) || (state == RUN));

    always_comb begin
        state_nxt   = state;
        set_timeout = 1'b0;
        case (state)
            PLL_RESET: begin
                if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (bus.sw_relock) state_nxt = PLL_RESET;
                else if (locked_s) state_nxt = STABLE;
                else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_nxt   = PLL_RESET;
                    set_timeout = 1'b1;
                end
            end
            STABLE: begin
                // The locked cycle that moved us out of WAIT_LOCK is the first of the run.
                if (bus.sw_relock) state_nxt = PLL_RESET;
                else if (!locked_s) state_nxt = WAIT_LOCK;
                else if (32'(cnt) + 32'd2 >= LOCK_STABLE_CYCLES) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (lock_loss || bus.sw_relock) state_nxt = PLL_RESET;
                else if (cnt == CNT_W'(RELEASE_GAP - 1)) state_nxt = RUN;
            end
            RUN: begin
                if (lock_loss || bus.sw_relock) state_nxt = PLL_RESET;
            end
            default: state_nxt = PLL_RESET;
        endcase

        if (state_nxt != state) cnt_nxt = '0;
        else if (state == RUN)  cnt_nxt = cnt;
        else                    cnt_nxt = cnt + 1'b1;
    end

    // Outputs are registered from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state             <= PLL_RESET;
            cnt               <= '0;
            bus.pll_rst       <= 1'b1;
            bus.rst_out0      <= 1'b1;
            bus.rst_out1      <= 1'b1;
            bus.ready         <= 1'b0;
            bus.lock_lost_cnt <= 8'd0;
            bus.timeout_err   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bus.pll_rst  <= (state_nxt == PLL_RESET);
            bus.rst_out0 <= (state_nxt != RELEASE) && (state_nxt != RUN);
            bus.rst_out1 <= (state_nxt != RUN);
            bus.ready    <= (state_nxt == RUN);
            if (lock_loss && (bus.lock_lost_cnt != 8'hFF))
                bus.lock_lost_cnt <= bus.lock_lost_cnt + 8'd1;
            if (set_timeout)
                bus.timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_soc_system_pll_reset_seq.sv
// Directed bench for the PLL reset sequencer with a phase/countdown reference model
// checked every cycle, plus hand-computed latency and width expectations.
module tb_soc_system_pll_reset_seq;

    localparam int PRC = 4;
    localparam int LSC = 8;
    localparam int TO  = 32;
    localparam int GAP = 2;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   total  = 0;
    int   bad    = 0;
    int   n;

    soc_system_pll_reset_seq_if bus();

    soc_system_pll_reset_seq #(
        .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
        .LOCK_TIMEOUT_CYCLES(TO), .RELEASE_GAP(GAP)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: named phase plus cycles left in it; lock seen through a 2-deep delay.
    localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_REL = 3, PH_RUN = 4;
    int   m_phase, m_left, m_lost;
    logic m_terr, q1, q2, lk;

    task automatic enter(input int p);
        m_phase = p;
        case (p)
            PH_RST:  m_left = PRC;
            PH_WAIT: m_left = TO;
            PH_STAB: m_left = LSC - 1;
            default: m_left = GAP;
        endcase
    endtask

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            enter(PH_RST);
            m_lost = 0; m_terr = 1'b0; q1 = 1'b0; q2 = 1'b0;
        end else begin
            lk = q2; q2 = q1; q1 = bus.pll_locked;
            case (m_phase)
                PH_RST: begin
                    m_left--;
                    if (m_left == 0) enter(PH_WAIT);
                end
                PH_WAIT: begin
                    if (bus.sw_relock) enter(PH_RST);
                    else if (lk) enter(PH_STAB);
                    else begin
                        m_left--;
                        if (m_left == 0) begin m_terr = 1'b1; enter(PH_RST); end
                    end
                end
                PH_STAB: begin
                    if (bus.sw_relock) enter(PH_RST);
                    else if (!lk) enter(PH_WAIT);
                    else begin
                        m_left--;
                        if (m_left == 0) enter(PH_REL);
                    end
                end
                default: begin
                    if (!lk) begin
                        if (m_lost < 255) m_lost++;
                        enter(PH_RST);
                    end else if (bus.sw_relock) enter(PH_RST);
                    else if (m_phase == PH_REL) begin
                        m_left--;
                        if (m_left == 0) enter(PH_RUN);
                    end
                end
            endcase
        end
    end

    initial forever begin
        @(posedge refclk); #1;
        if (!rst) begin
            check("model_pll_rst",  bus.pll_rst,  m_phase == PH_RST);
            check("model_rst_out0", bus.rst_out0, m_phase < PH_REL);
            check("model_rst_out1", bus.rst_out1, m_phase != PH_RUN);
            check("model_ready",    bus.ready,    m_phase == PH_RUN);
            check("model_lost_cnt", bus.lock_lost_cnt, m_lost);
            check("model_timeout",  bus.timeout_err, m_terr);
        end
    end

    task automatic tick();
        @(posedge refclk); #1;
    endtask

    function automatic logic sig(input int s);
        case (s)
            0:       return bus.pll_rst;
            1:       return bus.rst_out0;
            2:       return bus.rst_out1;
            3:       return bus.ready;
            default: return bus.timeout_err;
        endcase
    endfunction

    task automatic wait_for(input int s, input logic v, input int bound, output int cnt);
        cnt = 0;
        while (sig(s) !== v && cnt < bound) begin
            tick();
            cnt++;
        end
        check($sformatf("wait_sig%0d_reached", s), sig(s), v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},  bus.pll_rst, 1);
        check({tag, "_rst_out0"}, bus.rst_out0, 1);
        check({tag, "_rst_out1"}, bus.rst_out1, 1);
        check({tag, "_ready"},    bus.ready, 0);
        check({tag, "_lost"},     bus.lock_lost_cnt, 0);
        check({tag, "_timeout"},  bus.timeout_err, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pll_locked = 1'b0;
        bus.sw_relock  = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");

        // Nominal bring-up
        rst = 1'b0;
        wait_for(0, 1'b0, 20, n);
        check("pll_rst_width", n, 4);
        repeat (3) tick();
        bus.pll_locked = 1'b1;
        wait_for(1, 1'b0, 40, n);
        check("lock_to_rst_out0", n, 10);
        check("rst_out1_held", bus.rst_out1, 1);
        wait_for(3, 1'b1, 10, n);
        check("release_gap", n, 2);
        check("rst_out1_released", bus.rst_out1, 0);
        check("lost_after_bringup", bus.lock_lost_cnt, 0);
        repeat (5) tick();
        check("run_holds", bus.ready, 1);

        // sw_relock in RUN, then a second pulse inside PLL_RESET
        bus.sw_relock = 1'b1; tick(); bus.sw_relock = 1'b0;
        check("sw_run_pll_rst", bus.pll_rst, 1);
        check("sw_run_ready", bus.ready, 0);
        bus.pll_locked = 1'b0;
        tick();
        bus.sw_relock = 1'b1; tick(); bus.sw_relock = 1'b0;
        wait_for(0, 1'b0, 10, n);
        check("sw_in_reset_width", n + 2, 4);
        check("sw_lost_unchanged", bus.lock_lost_cnt, 0);

        // Glitch at stable count 5
        repeat (2) tick();
        bus.pll_locked = 1'b1;
        repeat (6) tick();
        bus.pll_locked = 1'b0; tick(); bus.pll_locked = 1'b1;
        wait_for(1, 1'b0, 40, n);
        check("glitch_release", n, 10);
        wait_for(3, 1'b1, 10, n);
        check("glitch_gap", n, 2);
        check("glitch_lost", bus.lock_lost_cnt, 0);

        // Lock loss in RUN followed by a timeout and a retry
        bus.pll_locked = 1'b0;
        wait_for(3, 1'b0, 10, n);
        check("loss_latency", n, 3);
        check("loss_rst_out1", bus.rst_out1, 1);
        check("lost_one", bus.lock_lost_cnt, 1);
        wait_for(0, 1'b0, 10, n);
        check("retry_pll_rst_width", n, 4);
        wait_for(4, 1'b1, 60, n);
        check("timeout_cycles", n, 32);
        check("timeout_repulse", bus.pll_rst, 1);
        wait_for(0, 1'b0, 10, n);
        check("timeout_pll_rst_width", n, 4);
        bus.pll_locked = 1'b1;
        wait_for(3, 1'b1, 60, n);
        check("timeout_sticky", bus.timeout_err, 1);

        // sw_relock coinciding with a lock loss counts once
        bus.pll_locked = 1'b0;
        repeat (2) tick();
        bus.sw_relock = 1'b1; tick(); bus.sw_relock = 1'b0;
        check("coincide_ready", bus.ready, 0);
        check("coincide_lost", bus.lock_lost_cnt, 2);
        bus.pll_locked = 1'b1;
        wait_for(3, 1'b1, 60, n);

        // Repeated losses saturate the counter
        for (int i = 0; i < 257; i++) begin
            bus.pll_locked = 1'b0;
            wait_for(3, 1'b0, 5, n);
            check("loop_loss_latency", n, 3);
            bus.pll_locked = 1'b1;
            wait_for(3, 1'b1, 60, n);
        end
        check("lost_saturated", bus.lock_lost_cnt, 255);
        check("lost_timeout_kept", bus.timeout_err, 1);

        // Asynchronous reset mid-cycle while in RUN
        tick();
        #5 rst = 1'b1;
        #1 check_reset_values("async");
        repeat (2) tick();
        rst = 1'b0;
        wait_for(0, 1'b0, 20, n);
        check("post_reset_pll_rst_width", n, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_system_pll_reset_seq.md
SOC_SYSTEM_PLL_RESET_SEQ -- requirements
Module: soc_system_pll_reset_seq

Interface
REQ-001: The block SHALL have parameter PLL_RST_CYCLES, default 10, which sets the number of refclk cycles that pll_rst is held high per reset attempt.
REQ-002: The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, which sets the number of consecutive synchronized-locked cycles required before releasing any reset.
REQ-003: The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 50000, which sets the number of cycles the block waits for lock before it retries the PLL reset.
REQ-004: The block SHALL have parameter RELEASE_GAP, default 16, which sets the number of cycles between deassertion of rst_out0 and deassertion of rst_out1.
REQ-005: The block SHALL have port refclk, input, 1 bit: the single clock, the PLL reference (50 MHz); all logic is in this domain.
REQ-006: The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007: The block SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
REQ-008: The block SHALL have port sw_relock, input, 1 bit: single-cycle software request to re-run the full sequence.
REQ-009: The block SHALL have port pll_rst, output, 1 bit: drives the PLL rst input.
REQ-010: The block SHALL have port rst_out0, output, 1 bit: active-high reset request for the outclk_0 (108 MHz) domain.
REQ-011: The block SHALL have port rst_out1, output, 1 bit: active-high reset request for the outclk_1 (154.29 MHz) domain.
REQ-012: The block SHALL have port ready, output, 1 bit: high only in RUN.
REQ-013: The block SHALL have port lock_lost_cnt, output, 8 bits: saturating count of lock losses after release.
REQ-014: The block SHALL have port timeout_err, output, 1 bit: sticky flag set by a lock timeout.

Function
REQ-015: pll_locked SHALL pass through a 2-flop synchronizer, producing locked_s; all decisions use locked_s, giving 2 cycles of input latency.
REQ-016: All outputs SHALL be registered.
REQ-017: The FSM SHALL have the states PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, and a single cycle counter that is cleared on every state entry.
REQ-018: In PLL_RESET: pll_rst=1, rst_out0=1, rst_out1=1, ready=0; after exactly PLL_RST_CYCLES cycles the FSM SHALL move to WAIT_LOCK.
REQ-019: In WAIT_LOCK: pll_rst=0; if locked_s=1, the FSM SHALL move to STABLE; else if the counter reaches LOCK_TIMEOUT_CYCLES-1, the block SHALL set timeout_err=1 and move to PLL_RESET.
REQ-020: In STABLE: if locked_s=0, the FSM SHALL return to WAIT_LOCK without incrementing lock_lost_cnt; after LOCK_STABLE_CYCLES consecutive cycles with locked_s=1, it SHALL move to RELEASE.
REQ-021: In RELEASE: rst_out0=0 from the first cycle and rst_out1 held at 1; after RELEASE_GAP cycles the FSM SHALL move to RUN.
REQ-022: In RUN: rst_out0=0, rst_out1=0, ready=1; the FSM SHALL hold in RUN indefinitely while locked_s=1.
REQ-023: On locked_s=0 in RELEASE or RUN, the FSM SHALL move to PLL_RESET on the next edge, asserting rst_out0=1, rst_out1=1 and ready=0 in that same cycle.
REQ-024: On a lock loss in RELEASE or RUN, lock_lost_cnt SHALL increment and saturate at 255.
REQ-025: sw_relock=1 in any state other than PLL_RESET SHALL force PLL_RESET on the next edge.
REQ-026: sw_relock=1 while in PLL_RESET SHALL be ignored; it SHALL NOT restart the count.
REQ-027: sw_relock SHALL NOT change lock_lost_cnt or timeout_err.
REQ-028: If sw_relock and a lock loss occur in the same cycle in RELEASE or RUN, lock_lost_cnt SHALL increment once.
REQ-029: timeout_err and lock_lost_cnt SHALL clear only on rst.
REQ-030: Counters SHALL be sized to clog2 of the largest parameter; no counter wrap SHALL be observable.

Reset
REQ-031: While rst=1, immediately and asynchronously: state=PLL_RESET, counter=0, synchronizer=0, pll_rst=1, rst_out0=1, rst_out1=1, ready=0, lock_lost_cnt=0, timeout_err=0.
REQ-032: rst asserted mid-sequence, including in RUN, SHALL abort immediately to these values, with no intermediate output states.
REQ-033: After rst deasserts, the first PLL_RESET period SHALL be the full PLL_RST_CYCLES.

Verification (bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_GAP=2)
REQ-034: Nominal bring-up: release rst, raise pll_locked 3 cycles after pll_rst falls -> pll_rst high for exactly 4 cycles; rst_out0 falls 8 cycles after locked_s rises; rst_out1 and ready rise/fall 2 cycles later; lock_lost_cnt=0.
REQ-035: Glitch during STABLE: pll_locked low for 1 cycle at stable count 5 -> FSM returns to WAIT_LOCK; rst_out0 stays 1; release occurs 8 full locked cycles after the glitch; lock_lost_cnt=0.
REQ-036: Timeout: pll_locked held 0 -> timeout_err=1 after 32 WAIT_LOCK cycles; pll_rst re-pulses for 4 cycles; a later lock completes bring-up with timeout_err still 1.
REQ-037: Lock loss in RUN, repeated 257 times -> each loss gives rst_out0=rst_out1=1 and ready=0 within 3 cycles of the pll_locked fall; lock_lost_cnt ends at 255.
REQ-038: sw_relock: pulse in RUN -> full 4-cycle pll_rst pulse, counter unchanged; pulse during PLL_RESET -> pll_rst width stays 4 cycles.
REQ-039: Async reset in RUN: assert rst between clock edges -> all outputs reach reset values before the next refclk edge.
